hart_dmem_arbiter: RTL and testbench



---
 rtl/hart_dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_hart_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_HARTS harts.
// An atomic flag on the granted hart holds the grant across a read-modify-write.
module hart_dmem_arbiter #(
  parameter int NUM_HARTS  = 2,
  parameter int XLEN       = 32,
  parameter int HART_IDX_W = $clog2(NUM_HARTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_HARTS-1:0]      i_h_memread,
  input  logic [NUM_HARTS-1:0]      i_h_wen,
  input  logic [NUM_HARTS-1:0]      i_h_atomic,
  input  logic [NUM_HARTS*XLEN-1:0] i_h_addr,
  input  logic [NUM_HARTS*XLEN-1:0] i_h_wdata,
  input  logic [NUM_HARTS*3-1:0]    i_h_f3,
  output logic [NUM_HARTS-1:0]      o_h_data_ready,
  output logic [XLEN-1:0]           o_h_rdata,
  input  logic                      i_mem_ready,
  input  logic [XLEN-1:0]           i_mem_rdata,
  output logic                      o_mem_memread,
  output logic                      o_mem_wen,
  output logic [XLEN-1:0]           o_mem_addr,
  output logic [XLEN-1:0]           o_mem_wdata,
  output logic [2:0]                o_mem_f3,
  output logic                      o_mem_atomic,
  output logic [HART_IDX_W-1:0]     o_grant
);

  typedef enum logic [1:0] {IDLE, BUSY, LOCK} state_e;

  state_e                  state_q;
  logic [HART_IDX_W-1:0]   grant_q;
  logic [HART_IDX_W-1:0]   last_grant_q;
  logic [HART_IDX_W-1:0]   pick_d;
  logic [HART_IDX_W-1:0]   cand;
  logic                    found;
  logic [NUM_HARTS-1:0]    req;
  logic                    any_req;
  logic                    req_g;
  logic                    atomic_g;

  assign req      = i_h_memread | i_h_wen;
  assign any_req  = |req;
  assign req_g    = req[grant_q];
  assign atomic_g = i_h_atomic[grant_q];

  // First requester scanning upward from the hart after the last one served.
  always_comb begin
    pick_d = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      cand = HART_IDX_W'((int'(last_grant_q) + i) % NUM_HARTS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        pick_d = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= HART_IDX_W'(NUM_HARTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (i_mem_ready) begin
            if (atomic_g) begin
              state_q <= LOCK;
            end else begin
              last_grant_q <= grant_q;
              state_q      <= IDLE;
            end
          end else if (!req_g) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        LOCK: begin
          if (req_g) begin
            state_q <= BUSY;
          end else if (!atomic_g) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory side is only live while a transfer is in flight; LOCK idles the bus.
  always_comb begin
    o_mem_memread  = 1'b0;
    o_mem_wen      = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_mem_f3       = '0;
    o_h_data_ready = '0;
    if (state_q == BUSY) begin
      o_mem_memread = i_h_memread[grant_q] & req_g;
      o_mem_wen     = i_h_wen[grant_q] & req_g;
      o_mem_addr    = i_h_addr[int'(grant_q)*XLEN +: XLEN];
      o_mem_wdata   = i_h_wdata[int'(grant_q)*XLEN +: XLEN];
      o_mem_f3      = i_h_f3[int'(grant_q)*3 +: 3];
      if (i_mem_ready) begin
        o_h_data_ready[grant_q] = 1'b1;
      end
    end
  end

  assign o_mem_atomic = (state_q != IDLE) & atomic_g;
  assign o_h_rdata    = i_mem_rdata;
  assign o_grant      = grant_q;

endmodule

// File: tb/tb_hart_dmem_arbiter.sv
// Self-checking bench for hart_dmem_arbiter with four harts: vector table,
// rotation scoreboard and hand-written atomic/reset/abort sequences.
module tb_hart_dmem_arbiter;
  localparam int N  = 4;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    h_rd, h_wen, h_at;
  logic [N*XL-1:0] h_addr, h_wdata;
  logic [N*3-1:0]  h_f3;
  logic            mem_ready;
  logic [XL-1:0]   mem_rdata;
  logic [N-1:0]    o_h_data_ready;
  logic [XL-1:0]   o_h_rdata;
  logic            o_mem_memread, o_mem_wen, o_mem_atomic;
  logic [XL-1:0]   o_mem_addr, o_mem_wdata;
  logic [2:0]      o_mem_f3;
  logic [1:0]      o_grant;

  int checks = 0;
  int errors = 0;

  hart_dmem_arbiter #(.NUM_HARTS(N), .XLEN(XL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_h_memread(h_rd), .i_h_wen(h_wen), .i_h_atomic(h_at),
    .i_h_addr(h_addr), .i_h_wdata(h_wdata), .i_h_f3(h_f3),
    .o_h_data_ready(o_h_data_ready), .o_h_rdata(o_h_rdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_mem_memread(o_mem_memread), .o_mem_wen(o_mem_wen),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_f3(o_mem_f3), .o_mem_atomic(o_mem_atomic), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  at;
    logic        mrdy;
    logic [31:0] mrdata;
    logic [3:0]  e_rdy;
    logic        e_rd;
    logic [31:0] e_addr;
    logic [1:0]  e_grant;
  } vec_t;

  typedef struct {
    int          hart;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[14];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; h_rd = '0; h_wen = '0; h_at = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int served;
    exp_t e;

    for (int k = 0; k < N; k++) begin
      h_addr[k*XL +: XL]  = 32'h100 * (k + 1);
      h_wdata[k*XL +: XL] = 32'hA0 + k;
      h_f3[k*3 +: 3]      = 3'(k);
    end

    // rst, rd, at, mrdy, mrdata | e_rdy, e_rd, e_addr, e_grant
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,   2'd0};
    vecs[1]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,   2'd0};
    vecs[2]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h100, 2'd0};
    vecs[3]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h100, 2'd0};
    vecs[4]  = '{1'b0, 4'h1, 4'h0, 1'b1, 32'hDEADBEEF, 4'h1, 1'b1, 32'h100, 2'd0};
    vecs[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,   2'd0};
    vecs[6]  = '{1'b0, 4'h0, 4'h0, 1'b1, 32'h55,       4'h0, 1'b0, 32'h0,   2'd0};
    vecs[7]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,   2'd0};
    vecs[8]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h100, 2'd0};
    vecs[9]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h100, 2'd0};
    vecs[10] = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h100, 2'd0};
    vecs[11] = '{1'b0, 4'h1, 4'h0, 1'b1, 32'h12345678, 4'h1, 1'b1, 32'h100, 2'd0};
    vecs[12] = '{1'b0, 4'h2, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,   2'd0};
    vecs[13] = '{1'b0, 4'h2, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h200, 2'd1};

    do_reset();
    for (int r = 0; r < 14; r++) begin
      rst = vecs[r].rst; h_rd = vecs[r].rd; h_at = vecs[r].at;
      mem_ready = vecs[r].mrdy; mem_rdata = vecs[r].mrdata;
      #1;
      chk($sformatf("vec%0d ready", r), 32'(o_h_data_ready), 32'(vecs[r].e_rdy));
      chk($sformatf("vec%0d memread", r), 32'(o_mem_memread), 32'(vecs[r].e_rd));
      chk($sformatf("vec%0d addr", r), o_mem_addr, vecs[r].e_addr);
      chk($sformatf("vec%0d grant", r), 32'(o_grant), 32'(vecs[r].e_grant));
      chk($sformatf("vec%0d rdata", r), o_h_rdata, vecs[r].mrdata);
      $display("vec %0d: ready=%b memread=%b addr=%h grant=%0d", r,
               o_h_data_ready, o_mem_memread, o_mem_addr, o_grant);
      step();
    end

    // All four harts request continuously; expect strict rotation 0,1,2,3,0.
    do_reset();
    h_rd = 4'hF;
    served = 0;
    for (int cyc = 0; cyc < 40 && served < 5; cyc++) begin
      mem_ready = 1'b0;
      #1;
      if (o_mem_memread) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h1000 + served;
        exp_q.push_back('{served % N, 32'h1000 + served});
        served++;
      end
      #1;
      if (o_h_data_ready != '0) begin
        if (exp_q.size() == 0) begin
          chk("rot spurious ready", 32'(o_h_data_ready), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rot ready onehot", 32'(o_h_data_ready), 32'(1) << e.hart);
          chk("rot grant", 32'(o_grant), 32'(e.hart));
          chk("rot addr", o_mem_addr, 32'h100 * (e.hart + 1));
          chk("rot rdata", o_h_rdata, e.rdata);
          $display("rotation txn: hart %0d rdata %h", o_grant, o_h_rdata);
        end
      end
      step();
    end
    mem_ready = 1'b0;
    chk("rot served", 32'(served), 32'd5);
    chk("rot pending", 32'(exp_q.size()), 32'd0);

    // Hart1 atomic read then write while hart0 keeps requesting.
    do_reset();
    h_rd = 4'b0010; h_at = 4'b0010;
    step();
    h_rd = 4'b0011;
    #1;
    chk("atom rd grant", 32'(o_grant), 32'd1);
    chk("atom rd memread", 32'(o_mem_memread), 32'd1);
    chk("atom rd addr", o_mem_addr, 32'h200);
    chk("atom rd flag", 32'(o_mem_atomic), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hA1;
    #1;
    chk("atom rd ready", 32'(o_h_data_ready), 32'h2);
    $display("atomic txn: read hart %0d rdata %h", o_grant, o_h_rdata);
    step();
    mem_ready = 1'b0;
    h_rd = 4'b0001; h_wen = 4'b0010;
    h_wdata[1*XL +: XL] = 32'hCAFE0001;
    #1;
    chk("atom lock grant", 32'(o_grant), 32'd1);
    chk("atom lock wen", 32'(o_mem_wen), 32'd0);
    chk("atom lock ready", 32'(o_h_data_ready), 32'h0);
    chk("atom lock flag", 32'(o_mem_atomic), 32'd1);
    step();
    #1;
    chk("atom wr wen", 32'(o_mem_wen), 32'd1);
    chk("atom wr grant", 32'(o_grant), 32'd1);
    chk("atom wr addr", o_mem_addr, 32'h200);
    chk("atom wr wdata", o_mem_wdata, 32'hCAFE0001);
    chk("atom wr f3", 32'(o_mem_f3), 32'd1);
    mem_ready = 1'b1;
    #1;
    chk("atom wr ready", 32'(o_h_data_ready), 32'h2);
    $display("atomic txn: write hart %0d", o_grant);
    step();
    mem_ready = 1'b0; h_wen = 4'b0000;
    #1;
    chk("atom hold grant", 32'(o_grant), 32'd1);
    chk("atom hold memread", 32'(o_mem_memread), 32'd0);
    step();
    chk("atom hold2 grant", 32'(o_grant), 32'd1);
    h_at = 4'b0000;
    step();
    step();
    #1;
    chk("atom after grant", 32'(o_grant), 32'd0);
    chk("atom after memread", 32'(o_mem_memread), 32'd1);
    chk("atom after addr", o_mem_addr, 32'h100);

    // Reset while hart2 holds a write grant.
    do_reset();
    h_wen = 4'b0100;
    step();
    #1;
    chk("rst busy grant", 32'(o_grant), 32'd2);
    chk("rst busy wen", 32'(o_mem_wen), 32'd1);
    chk("rst busy addr", o_mem_addr, 32'h300);
    rst = 1'b1;
    step();
    rst = 1'b0; h_wen = 4'b0000; mem_ready = 1'b1;
    #1;
    chk("rst after wen", 32'(o_mem_wen), 32'd0);
    chk("rst after grant", 32'(o_grant), 32'd0);
    chk("rst late ready", 32'(o_h_data_ready), 32'h0);
    step();
    mem_ready = 1'b0;

    // Hart3 aborts before ready; next arbitration starts at hart0.
    do_reset();
    h_rd = 4'b0010;
    step();
    mem_ready = 1'b1;
    #1;
    chk("abort pre ready", 32'(o_h_data_ready), 32'h2);
    step();
    mem_ready = 1'b0; h_rd = 4'b1000;
    step();
    #1;
    chk("abort grant", 32'(o_grant), 32'd3);
    chk("abort addr", o_mem_addr, 32'h400);
    h_rd = 4'b0000;
    #1;
    chk("abort memread gated", 32'(o_mem_memread), 32'd0);
    step();
    h_rd = 4'b0101;
    step();
    #1;
    chk("abort next grant", 32'(o_grant), 32'd0);
    chk("abort next addr", o_mem_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
